// File: rtl/uart_fifo_ctrl.sv
// Buffered UART: TX/RX FIFOs with valid/ready streams, programmable baud divider, sticky errors.
// Latency: a TX write accepted at edge N drives the start bit at edge N+1; rx_valid rises the edge after the stop sample.
// Backpressure: tx_ready drops when the TX FIFO is full; a full RX FIFO drops new characters and raises rx_overrun.
// Optional CTS/RTS flow control is enabled by defining UART_FLOWCTL_EN.

// Generic FIFO with first-word fall-through read; a push into a full FIFO is refused.
module uart_fifo_ctrl_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [W-1:0]     pop_dat,
    input  logic             pop_rdy,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign push_rdy = (cnt_q != LVL_W'(DEPTH));
    assign pop_vld  = (cnt_q != '0);
    assign pop_dat  = mem_q[rd_ptr_q];
    assign level    = cnt_q;
    assign push     = push_vld && push_rdy;
    assign pop      = pop_rdy && pop_vld;

    // Occupancy next state: simultaneous push and pop cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_dat;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

module uart_fifo_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                              clk_clk,
    input  logic                              reset_reset,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic [DATA_BITS-1:0]              tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    input  logic                              clear_err,
    output logic                              rx_overrun,
    output logic                              rx_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]       tx_level,
    output logic [$clog2(FIFO_DEPTH):0]       rx_level,
    output logic                              uart_txd,
    input  logic                              uart_rxd,
    input  logic                              uart_cts_n,
    output logic                              uart_rts_n
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                 tx_nempty, tx_pop, cts_ok;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_push, rx_nfull, fe_set, ov_set;

    uart_fifo_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
        .clk(clk_clk), .rst(reset_reset),
        .push_vld(tx_valid), .push_dat(tx_data), .push_rdy(tx_ready),
        .pop_vld(tx_nempty), .pop_dat(tx_head), .pop_rdy(tx_pop), .level(tx_level)
    );

    // ---------------- TX ----------------
    logic [1:0]           tx_st_q, tx_st_d;
    logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d, tx_tick;

    assign tx_tick = (tx_cnt_q == '0);

    // TX frame sequencing; a new frame launches from IDLE or straight out of STOP.
    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        if (tx_st_q != S_IDLE)
            tx_cnt_d = tx_tick ? tx_div_q : tx_cnt_q - 1'b1;
        case (tx_st_q)
            S_START: if (tx_tick) begin
                tx_st_d    = S_DATA;
                tx_bit_d   = '0;
                txd_d      = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
            end
            S_DATA: if (tx_tick) begin
                if (tx_bit_q == LAST_BIT) begin
                    tx_st_d = S_STOP;
                    txd_d   = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
            end
            S_STOP: if (tx_tick) tx_st_d = S_IDLE;
            default: ;
        endcase
        // baud_div is captured only here so mid-frame changes wait for the next frame.
        if ((tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_tick)) && tx_nempty && cts_ok) begin
            tx_pop     = 1'b1;
            tx_st_d    = S_START;
            txd_d      = 1'b0;
            tx_cnt_d   = baud_div;
            tx_div_d   = baud_div;
            tx_shift_d = tx_head;
        end
    end

    // TX state registers; reset forces the line idle at once.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tx_st_q    <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign uart_txd = txd_q;

    // ---------------- RX ----------------
    logic [1:0]           rx_st_q, rx_st_d;
    logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rxd_s1_q, rxd_s2_q, rxd_s3_q, rx_tick, rx_sample;
    logic                 fe_q, ov_q;

    // (div+1)/2 without a wider intermediate.
    assign rx_half   = {1'b0, rx_div_q[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, rx_div_q[0]};
    assign rx_tick   = (rx_cnt_q == '0);
    assign rx_sample = (rx_cnt_q == rx_half);

    // RX frame sequencing; leaves STOP at the mid-bit sample to leave resync margin.
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        ov_set     = 1'b0;
        if (rx_st_q != S_IDLE)
            rx_cnt_d = rx_tick ? rx_div_q : rx_cnt_q - 1'b1;
        case (rx_st_q)
            S_IDLE: if (rxd_s3_q && !rxd_s2_q) begin
                rx_st_d  = S_START;
                rx_cnt_d = baud_div;
                rx_div_d = baud_div;
            end
            S_START: begin
                if (rx_sample && rxd_s2_q)
                    rx_st_d = S_IDLE;
                else if (rx_tick) begin
                    rx_st_d  = S_DATA;
                    rx_bit_d = '0;
                end
            end
            S_DATA: begin
                if (rx_sample)
                    rx_shift_d = {rxd_s2_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_tick) begin
                    if (rx_bit_q == LAST_BIT) rx_st_d  = S_STOP;
                    else                      rx_bit_d = rx_bit_q + 1'b1;
                end
            end
            default: if (rx_sample || rx_tick) begin
                rx_st_d = S_IDLE;
                if (!rxd_s2_q)     fe_set  = 1'b1;
                else if (rx_nfull) rx_push = 1'b1;
                else               ov_set  = 1'b1;
            end
        endcase
    end

    // RX synchroniser, state and sticky flags; a set in the same cycle as clear_err wins.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_s3_q   <= 1'b1;
            rx_st_q    <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            rxd_s1_q   <= uart_rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_s3_q   <= rxd_s2_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            fe_q       <= fe_set | (fe_q & ~clear_err);
            ov_q       <= ov_set | (ov_q & ~clear_err);
        end
    end

    assign rx_frame_err = fe_q;
    assign rx_overrun   = ov_q;

    uart_fifo_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
        .clk(clk_clk), .rst(reset_reset),
        .push_vld(rx_push), .push_dat(rx_shift_q), .push_rdy(rx_nfull),
        .pop_vld(rx_valid), .pop_dat(rx_data), .pop_rdy(rx_ready), .level(rx_level)
    );

    // ---------------- Flow control ----------------
`ifdef UART_FLOWCTL_EN
    logic cts_s1_q, cts_s2_q, rts_q;

    // CTS synchroniser (resets to "not clear") and registered RTS threshold.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cts_s1_q <= 1'b1;
            cts_s2_q <= 1'b1;
            rts_q    <= 1'b0;
        end else begin
            cts_s1_q <= uart_cts_n;
            cts_s2_q <= cts_s1_q;
            rts_q    <= (rx_level >= LVL_W'(FIFO_DEPTH - 2));
        end
    end

    assign cts_ok     = !cts_s2_q;
    assign uart_rts_n = rts_q;
`else
    logic unused_cts;
    assign unused_cts = uart_cts_n;
    assign cts_ok     = 1'b1;
    assign uart_rts_n = 1'b0;
`endif
endmodule
